step1_ctrl: RTL and testbench
=============================

# step1_ctrl

Sequencer for the first radix-2 stage of the 16-lane FFT pipeline. It counts input beats per frame and drives the stage's control:

- the 16-lane shift-register enables;
- the butterfly input-mux select;
- the butterfly enable;
- output-valid tagging.

When input stops it self-generates a flush window so the frame tail drains through the delay lines. It sits beside the stage datapath and replaces the ad-hoc counters inside it.

## Interface

Parameters:
- FRAME_LEN, 32: beats (16-sample words) per frame; power of two.
- SPLIT, 2: beat indices below SPLIT select the direct path (mux_sel=0); the rest select the long delay line (mux_sel=1).
- FILL, 2: shift beats after leaving IDLE whose butterfly result is discarded (delay-line fill).
- PIPE_LAT, 2: butterfly latency in cycles, from bfly_en to result.
- CNT_W, $clog2(FRAME_LEN): beat index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- din_valid  in  1  input word present this cycle; always accepted; no backpressure.
- sr_en  out  1  shift enable for both delay lines.
- mux_sel  out  1  0 = direct input to butterfly/SR_16; 1 = SR_32 output.
- beat_idx  out  CNT_W  index of the beat being shifted, 0..FRAME_LEN-1.
- bfly_en  out  1  butterfly operand enable.
- dout_valid  out  1  butterfly output carries real data.
- frame_start  out  1  pulse with sr_en on beat 0 of a data frame.
- frame_done  out  1  one-cycle pulse when flush completes and the block returns to IDLE.
- busy  out  1  state != IDLE.

## Operation

- States are IDLE, RUN and FLUSH. Internal registers:
  - idx, CNT_W bits;
  - flush_cnt, CNT_W+1 bits;
  - fill_cnt, saturating at FILL;
  - tag shift register, PIPE_LAT deep.
- IDLE:
  - din_valid=1 → RUN. Registered outputs next cycle: sr_en=1, beat_idx=0, frame_start=1.
- RUN:
  - Each din_valid beat produces one shift beat with beat_idx=idx; idx then increments modulo FRAME_LEN.
  - din_valid=0 mid-frame: sr_en=0; idx and all outputs hold. Gaps are legal and of any length.
  - Beat FRAME_LEN-1 accepted, and din_valid=1 on the next cycle: stay RUN; that beat is beat 0 of the next frame (frame_start=1). No flush.
  - Beat FRAME_LEN-1 accepted, and din_valid=0 on the next cycle: → FLUSH with flush_cnt=FRAME_LEN.
- FLUSH:
  - Each cycle generates an internal shift beat: sr_en=1, frame_start=0. beat_idx continues modulo FRAME_LEN, and mux_sel follows beat_idx. flush_cnt decrements.
  - din_valid=1 in any FLUSH cycle, including the cycle flush_cnt reaches 1: abort flush → RUN. That beat is beat 0 with frame_start=1.
  - flush_cnt reaches 0 with no din_valid → IDLE. Pulse frame_done; fill_cnt clears.
- mux_sel = (beat_idx >= SPLIT), registered alongside beat_idx.
- fill_cnt increments on every shift beat (data or flush) until it reaches FILL.
- tag = sr_en & (fill_cnt >= FILL), evaluated for the beat being shifted.
- dout_valid = tag delayed PIPE_LAT+1 cycles, aligned with the butterfly result.

## Timing

- Every output is a register. Reset value of every output is 0. idx, flush_cnt, fill_cnt and tags reset to 0; state resets to IDLE.
- din_valid sampled at cycle t:
  - sr_en, beat_idx, mux_sel, frame_start at t+1;
  - bfly_en = sr_en delayed 1 cycle, at t+2;
  - dout_valid at t+2+PIPE_LAT (t+4 with defaults).
- Flush length is exactly FRAME_LEN sr_en cycles. frame_done comes on the cycle after the last flush beat, with busy=0 that same cycle.
- Reset asserted mid-frame or mid-flush: all outputs 0 on the next cycle. In-flight tags are dropped and no dout_valid appears afterwards.
- With defaults, an isolated frame yields 2·FRAME_LEN − FILL = 62 dout_valid beats.

## Test plan

- Reset: hold rstn=0 with din_valid toggling → all outputs 0. Release with din_valid=0 → outputs stay 0, busy=0.
- Single frame, 32 contiguous beats from cycle 0:
  - sr_en high cycles 1..64; beat_idx 0..31 twice;
  - mux_sel=0 only at idx 0,1;
  - frame_start at cycle 1 only;
  - dout_valid 62 cycles, from cycle 6 to 67;
  - frame_done at cycle 65.
- Back-to-back: 64 contiguous beats → no FLUSH between frames; frame_start at cycles 1 and 33; one flush of 32 beats follows; exactly one frame_done.
- Gap: 10 beats, 5 idle cycles, 22 beats → sr_en=0 for exactly the 5 gap cycles; beat_idx holds at 9, then resumes at 10; flush begins after beat 31.
- Flush abort: new din_valid at the 12th flush beat → FLUSH exits; beat_idx=0 with frame_start=1; no frame_done; dout_valid continues without a FILL drop.
- Reset mid-flush: rstn=0 for 1 cycle at flush beat 8 → outputs 0 next cycle. A subsequent frame behaves exactly as in the single-frame case.

Source files
------------

// File: rtl/step1_ctrl.sv
// ---------------------------------------------------------------------------
// step1_ctrl
//
// Sequencer for the first radix-2 stage of the 16-lane FFT pipeline. It
// counts input beats within a frame and drives the stage control: the
// shift-register enable, the butterfly input-mux select, the butterfly
// enable and the output-valid tag. When input stops at a frame boundary it
// generates a flush window of FRAME_LEN internal shift beats, so the frame
// tail drains through the delay lines.
//
// Handshake: din_valid is a pure valid. There is no ready and no
// backpressure. Every cycle with din_valid=1 is one accepted input word, and
// it produces exactly one shift beat one cycle later.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rstn         synchronous active-low reset
//   din_valid    input word present this cycle
//   sr_en        shift enable for both delay lines (data or flush beat)
//   mux_sel      0 = direct input path, 1 = long delay-line output
//   beat_idx     index of the beat being shifted, 0..FRAME_LEN-1
//   bfly_en      butterfly operand enable (sr_en delayed one cycle)
//   dout_valid   butterfly output carries real data
//   frame_start  pulse together with sr_en on beat 0 of a data frame
//   frame_done   one-cycle pulse when a flush completes (back in IDLE)
//   busy         controller is not idle
//   state_dbg    current FSM state (0 = IDLE, 1 = RUN, 2 = FLUSH)
// ---------------------------------------------------------------------------
module step1_ctrl #(
  parameter int FRAME_LEN = 32,
  parameter int SPLIT     = 2,
  parameter int FILL      = 2,
  parameter int PIPE_LAT  = 2,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_valid,
  output logic             sr_en,
  output logic             mux_sel,
  output logic [CNT_W-1:0] beat_idx,
  output logic             bfly_en,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // fill_cnt only needs to count up to FILL; keep at least one bit so a
  // FILL of 0 still elaborates.
  localparam int FILL_W = (FILL < 1) ? 1 : $clog2(FILL + 1);

  localparam logic [CNT_W:0]    FLUSH_LEN = (CNT_W + 1)'(FRAME_LEN);
  localparam logic [CNT_W:0]    SPLIT_V   = (CNT_W + 1)'(SPLIT);
  localparam logic [CNT_W:0]    FLUSH_ONE = (CNT_W + 1)'(1);
  localparam logic [FILL_W-1:0] FILL_V    = FILL_W'(FILL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // Index of the next beat to shift. Because FRAME_LEN is a power of two,
  // the natural CNT_W-bit wrap gives the modulo.
  logic [CNT_W-1:0]    idx;

  // Number of flush beats still to be shown, counting the current one.
  // It is loaded with FRAME_LEN on the edge that emits the first flush beat.
  logic [CNT_W:0]      flush_cnt;

  // Shift beats since the last IDLE, saturating at FILL. The first FILL
  // beats only fill the delay lines, so their butterfly results are junk.
  logic [FILL_W-1:0]   fill_cnt;

  // tag_q is aligned with sr_en. tag_sr carries it through the butterfly
  // latency, and dout_valid is the final register stage.
  logic                tag_q;
  logic [PIPE_LAT-1:0] tag_sr;

  // Per-edge decode
  logic                shift_go;   // a shift beat is emitted on this edge
  logic                start_go;   // that beat is beat 0 of a data frame
  logic                done_go;    // flush ends on this edge
  logic                flush_load; // entering FLUSH
  logic                flush_dec;  // flush beat consumed while in FLUSH
  logic [CNT_W-1:0]    shift_idx;  // index carried by the emitted beat

  always_comb begin
    state_nxt  = state;
    shift_go   = 1'b0;
    start_go   = 1'b0;
    done_go    = 1'b0;
    flush_load = 1'b0;
    flush_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (din_valid) begin
          state_nxt = S_RUN;
          shift_go  = 1'b1;
          start_go  = 1'b1;
        end
      end
      S_RUN: begin
        // In RUN, idx is 0 only in the cycle right after beat FRAME_LEN-1
        // was accepted. The IDLE->RUN and FLUSH->RUN edges already consume
        // beat 0, so idx is never 0 at the start of a frame.
        if (din_valid) begin
          shift_go = 1'b1;
          start_go = (idx == '0);
        end else if (idx == '0) begin
          state_nxt  = S_FLUSH;
          shift_go   = 1'b1;
          flush_load = 1'b1;
        end
      end
      S_FLUSH: begin
        if (din_valid) begin
          // New data aborts the flush and starts a fresh frame at beat 0.
          state_nxt = S_RUN;
          shift_go  = 1'b1;
          start_go  = 1'b1;
        end else if (flush_cnt == FLUSH_ONE) begin
          state_nxt = S_IDLE;
          done_go   = 1'b1;
          flush_dec = 1'b1;
        end else begin
          shift_go  = 1'b1;
          flush_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A data frame always restarts at index 0, whatever the flush had reached.
  assign shift_idx = start_go ? '0 : idx;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      idx         <= '0;
      flush_cnt   <= '0;
      fill_cnt    <= '0;
      tag_q       <= 1'b0;
      tag_sr      <= '0;
      sr_en       <= 1'b0;
      mux_sel     <= 1'b0;
      beat_idx    <= '0;
      bfly_en     <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr_en       <= shift_go;
      frame_start <= start_go;
      frame_done  <= done_go;
      busy        <= (state_nxt != S_IDLE);
      bfly_en     <= sr_en;

      // The tag is judged on the fill level before this beat is counted.
      tag_q       <= shift_go & (fill_cnt >= FILL_V);
      tag_sr      <= (tag_sr << 1) | PIPE_LAT'(tag_q);
      dout_valid  <= tag_sr[PIPE_LAT-1];

      // beat_idx and mux_sel hold through gaps and idle periods.
      if (shift_go) begin
        beat_idx <= shift_idx;
        mux_sel  <= ({1'b0, shift_idx} >= SPLIT_V);
        idx      <= shift_idx + 1'b1;
      end

      // A flush abort keeps the fill level: the delay lines are already
      // full of real samples from the previous frame.
      if (done_go) begin
        fill_cnt <= '0;
      end else if (shift_go && (fill_cnt < FILL_V)) begin
        fill_cnt <= fill_cnt + 1'b1;
      end

      if (flush_load) begin
        flush_cnt <= FLUSH_LEN;
      end else if (flush_dec) begin
        flush_cnt <= flush_cnt - 1'b1;
      end else if (start_go) begin
        flush_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_step1_ctrl.sv
// ---------------------------------------------------------------------------
// tb_step1_ctrl
//
// Directed bench for step1_ctrl with the default parameters. Each scenario
// fills a per-cycle din_valid / rstn pattern and replays it. The outputs of
// every cycle are recorded as one packed word:
//   {sr_en, mux_sel, beat_idx[4:0], bfly_en, dout_valid, frame_start,
//    frame_done, busy}
// and compared with hand-derived expectations queued in exp_q.
// Cycle 0 is the first cycle in which the scenario drives din_valid.
// ---------------------------------------------------------------------------
module tb_step1_ctrl;

  localparam int FRAME_LEN = 32;
  localparam int SPLIT     = 2;
  localparam int FILL      = 2;
  localparam int PIPE_LAT  = 2;
  localparam int CNT_W     = 5;
  localparam int VW        = 12;
  localparam int MAXC      = 160;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  logic din_valid;

  always #5 clk = ~clk;

  logic             sr_en;
  logic             mux_sel;
  logic [CNT_W-1:0] beat_idx;
  logic             bfly_en;
  logic             dout_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;
  logic [1:0]       state_dbg;

  step1_ctrl #(
    .FRAME_LEN (FRAME_LEN),
    .SPLIT     (SPLIT),
    .FILL      (FILL),
    .PIPE_LAT  (PIPE_LAT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .din_valid   (din_valid),
    .sr_en       (sr_en),
    .mux_sel     (mux_sel),
    .beat_idx    (beat_idx),
    .bfly_en     (bfly_en),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic          din_pat [MAXC];
  logic          rst_pat [MAXC];
  logic [VW-1:0] obs     [MAXC];
  logic [VW-1:0] exp_q   [$];

  // expected-word builder; mux_sel is (beat_idx >= SPLIT)
  function automatic logic [VW-1:0] pack(input logic sr, input int idx,
                                         input logic bf, input logic dv,
                                         input logic fs, input logic fd,
                                         input logic by);
    logic [CNT_W-1:0] i5;
    logic             ms;
    i5 = CNT_W'(idx);
    ms = (idx >= SPLIT);
    return {sr, ms, i5, bf, dv, fs, fd, by};
  endfunction

  // Isolated frame of 32 beats driven in cycles 0..31, starting from reset:
  // data beats in cycles 1..32, flush beats in 33..64, done in 65.
  function automatic logic [VW-1:0] exp_single(input int c);
    logic sr;
    int   idx;
    sr  = (c >= 1 && c <= 64);
    idx = sr ? (c - 1) % 32 : ((c >= 65) ? 31 : 0);
    return pack(sr, idx, (c >= 2 && c <= 65), (c >= 6 && c <= 67),
                (c == 1), (c == 65), sr);
  endfunction

  // driver tasks
  task automatic clear_pat();
    for (int k = 0; k < MAXC; k++) begin
      din_pat[k] = 1'b0;
      rst_pat[k] = 1'b1;
    end
  endtask

  task automatic set_din(input int from, input int to);
    for (int k = from; k <= to; k++) din_pat[k] = 1'b1;
  endtask

  // Leaves the bench #1 after an edge that sampled rstn=0, so the current
  // cycle shows reset outputs and is cycle 0 of the next scenario.
  task automatic apply_reset();
    rstn      = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      din_valid = din_pat[k];
      rstn      = rst_pat[k];
      @(negedge clk);
      obs[k] = {sr_en, mux_sel, beat_idx, bfly_en, dout_valid,
                frame_start, frame_done, busy};
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    rstn      = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    logic [VW-1:0] v;
    rstn      = 1'b0;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) begin
        rstn      = 1'b0;
        din_valid = k[0];
      end else begin
        rstn      = 1'b1;
        din_valid = 1'b0;
      end
      @(negedge clk);
      v = {sr_en, mux_sel, beat_idx, bfly_en, dout_valid,
           frame_start, frame_done, busy};
      n_checks++;
      if (v !== '0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: outputs %b, required all zero", k, v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_frame();
    logic [VW-1:0] e;
    int            dv_cnt;
    apply_reset();
    clear_pat();
    set_din(0, 31);
    run(72);
    for (int c = 0; c < 72; c++) exp_q.push_back(exp_single(c));
    dv_cnt = 0;
    for (int c = 0; c < 72; c++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs[c] !== e) begin
        n_fail++;
        $display("FAIL single_frame cycle %0d: got %b expected %b", c, obs[c], e);
      end
      if (obs[c][3] === 1'b1) dv_cnt++;
    end
    n_checks++;
    if (dv_cnt != 62) begin
      n_fail++;
      $display("FAIL single_frame_dv_count: got %0d expected 62", dv_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e;
    logic          sr;
    int            idx;
    int            fd_cnt;
    apply_reset();
    clear_pat();
    set_din(0, 63);
    run(104);
    for (int c = 0; c < 104; c++) begin
      sr  = (c >= 1 && c <= 96);
      idx = sr ? (c - 1) % 32 : ((c >= 97) ? 31 : 0);
      exp_q.push_back(pack(sr, idx, (c >= 2 && c <= 97), (c >= 6 && c <= 99),
                           (c == 1 || c == 33), (c == 97), sr));
    end
    fd_cnt = 0;
    for (int c = 0; c < 104; c++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs[c] !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs[c], e);
      end
      if (obs[c][1] === 1'b1) fd_cnt++;
    end
    n_checks++;
    if (fd_cnt != 1) begin
      n_fail++;
      $display("FAIL back_to_back_done_count: got %0d expected 1", fd_cnt);
    end
  endtask

  task automatic test_gap();
    logic [VW-1:0] e;
    logic          sr;
    int            idx;
    apply_reset();
    clear_pat();
    set_din(0, 9);
    set_din(15, 36);
    run(76);
    for (int c = 0; c < 76; c++) begin
      sr = (c >= 1 && c <= 10) || (c >= 16 && c <= 69);
      if (c == 0)                idx = 0;
      else if (c <= 10)          idx = c - 1;
      else if (c <= 15)          idx = 9;
      else if (c <= 37)          idx = c - 6;
      else if (c <= 69)          idx = c - 38;
      else                       idx = 31;
      exp_q.push_back(pack(sr, idx,
                           (c >= 2 && c <= 11) || (c >= 17 && c <= 70),
                           (c >= 6 && c <= 13) || (c >= 19 && c <= 72),
                           (c == 1), (c == 70), (c >= 1 && c <= 69)));
    end
    for (int c = 0; c < 76; c++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs[c] !== e) begin
        n_fail++;
        $display("FAIL gap cycle %0d: got %b expected %b", c, obs[c], e);
      end
    end
  endtask

  // din_valid returns during the 12th flush beat (cycle 44)
  task automatic test_flush_abort();
    logic [VW-1:0] e;
    logic          sr;
    int            idx;
    apply_reset();
    clear_pat();
    set_din(0, 31);
    set_din(44, 75);
    run(116);
    for (int c = 0; c < 116; c++) begin
      sr = (c >= 1 && c <= 108);
      if (c == 0)          idx = 0;
      else if (c <= 32)    idx = c - 1;
      else if (c <= 44)    idx = c - 33;
      else if (c <= 76)    idx = c - 45;
      else if (c <= 108)   idx = c - 77;
      else                 idx = 31;
      exp_q.push_back(pack(sr, idx, (c >= 2 && c <= 109), (c >= 6 && c <= 111),
                           (c == 1 || c == 45), (c == 109), sr));
    end
    for (int c = 0; c < 116; c++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs[c] !== e) begin
        n_fail++;
        $display("FAIL flush_abort cycle %0d: got %b expected %b", c, obs[c], e);
      end
    end
  endtask

  // reset during the 8th flush beat (cycle 40), new frame from cycle 45
  task automatic test_reset_mid_flush();
    logic [VW-1:0] e;
    apply_reset();
    clear_pat();
    set_din(0, 31);
    rst_pat[40] = 1'b0;
    set_din(45, 76);
    run(117);
    for (int c = 0; c < 117; c++) begin
      if (c <= 40)      exp_q.push_back(exp_single(c));
      else if (c <= 44) exp_q.push_back('0);
      else              exp_q.push_back(exp_single(c - 45));
    end
    for (int c = 0; c < 117; c++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs[c] !== e) begin
        n_fail++;
        $display("FAIL reset_mid_flush cycle %0d: got %b expected %b", c, obs[c], e);
      end
    end
  endtask

  initial begin
    rstn      = 1'b0;
    din_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_flush_abort();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
